// File: rtl/bus_arbiter.sv
// Four-way round-robin bus arbiter with bounded ownership and a one-cycle
// turnaround between owners so the mux select is stable under any live grant.
module bus_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       bus_en,
   output logic       preempt
);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     state, next_state;
   logic [7:0] hold_cnt, next_hold_cnt;
   logic [1:0] last_owner, next_last_owner;
   logic [3:0] next_grant;
   logic [1:0] next_sel;
   logic       next_preempt;
   logic       win_valid;
   logic [1:0] win_idx;
   logic       owner_req;
   logic       hold_ok;

   assign owner_req = req[last_owner];
   assign hold_ok   = (hold_cnt < HOLD_LAST);

   // Scan from the far end back so the nearest requester after last_owner wins.
   always_comb begin
      logic [1:0] cand;
      win_valid = 1'b0;
      win_idx   = last_owner;
      cand      = last_owner;
      for (int k = 4; k >= 1; k--) begin
         cand = last_owner + 2'(k);
         if (req[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold_cnt   <= 8'd0;
         last_owner <= 2'd3;
         grant      <= 4'd0;
         sel        <= 2'd0;
         bus_en     <= 1'b0;
         preempt    <= 1'b0;
      end else begin
         state      <= next_state;
         hold_cnt   <= next_hold_cnt;
         last_owner <= next_last_owner;
         grant      <= next_grant;
         sel        <= next_sel;
         bus_en     <= |next_grant;
         preempt    <= next_preempt;
      end
   end

   always_comb begin
      next_state      = state;
      next_hold_cnt   = hold_cnt;
      next_last_owner = last_owner;
      case (state)
         IDLE, TURN: begin
            if (win_valid) begin
               next_state      = GRANT;
               next_hold_cnt   = 8'd0;
               next_last_owner = win_idx;
            end else begin
               next_state = IDLE;
            end
         end
         GRANT: begin
            if (owner_req && hold_ok) begin
               next_hold_cnt = hold_cnt + 8'd1;
            end else begin
               next_state = TURN;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Only a fresh grant may move sel; a timeout is the one GRANT->TURN exit with req still up.
   always_comb begin
      next_grant   = 4'd0;
      next_sel     = sel;
      next_preempt = 1'b0;
      case (next_state)
         GRANT: begin
            if (state != GRANT) begin
               next_grant = 4'b0001 << win_idx;
               next_sel   = win_idx;
            end else begin
               next_grant = grant;
            end
         end
         TURN: next_preempt = (state == GRANT) && owner_req;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: two instances (MAX_HOLD 8 and 2) share req
// and are checked against a behavioural model plus structural invariants.
module tb_bus_arbiter;

   typedef struct {
      int         phase;
      int         owner;
      int         last;
      int         beats;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       preempt;
   } model_t;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] sel;
      logic       bus_en;
      logic       preempt;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] grant8, grant2;
   logic [1:0] sel8, sel2;
   logic       bus_en8, bus_en2;
   logic       preempt8, preempt2;

   int tests  = 0;
   int failed = 0;

   model_t m8, m2;
   exp_t   q8[$];
   exp_t   q2[$];

   logic [3:0] prev_grant8, prev_grant2;
   logic [1:0] prev_sel8, prev_sel2;
   logic       prev_en8, prev_en2;
   int         run8, run2;

   bus_arbiter #(.MAX_HOLD(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .grant(grant8), .sel(sel8), .bus_en(bus_en8), .preempt(preempt8)
   );

   bus_arbiter #(.MAX_HOLD(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .grant(grant2), .sel(sel2), .bus_en(bus_en2), .preempt(preempt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic model_t modelReset();
      model_t m;
      m.phase   = 0;
      m.owner   = 0;
      m.last    = 3;
      m.beats   = 0;
      m.grant   = 4'd0;
      m.sel     = 2'd0;
      m.preempt = 1'b0;
      return m;
   endfunction

   // phase: 0 idle, 1 owned, 2 turnaround
   function automatic model_t modelStep(model_t m, logic [3:0] r, int max_hold);
      model_t n = m;
      n.preempt = 1'b0;
      if (m.phase == 1) begin
         if (r[m.owner] && m.beats < max_hold) begin
            n.beats = m.beats + 1;
         end else begin
            n.phase   = 2;
            n.grant   = 4'd0;
            n.preempt = r[m.owner];
         end
      end else begin
         n.phase = 0;
         n.grant = 4'd0;
         for (int k = 1; k <= 4; k++) begin
            int idx = (m.last + k) % 4;
            if (n.phase == 0 && r[idx]) begin
               n.phase = 1;
               n.owner = idx;
               n.last  = idx;
               n.beats = 1;
               n.grant = 4'd0;
               n.grant[idx] = 1'b1;
               n.sel   = 2'(idx);
            end
         end
      end
      return n;
   endfunction

   function automatic exp_t toExp(model_t m);
      exp_t e;
      e.grant   = m.grant;
      e.sel     = m.sel;
      e.bus_en  = (m.grant != 4'd0);
      e.preempt = m.preempt;
      return e;
   endfunction

   task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkInvariants(input string tag, input int max_hold,
                                  input logic [3:0] g, input logic [1:0] s, input logic en,
                                  input logic [3:0] pg, input logic [1:0] ps, input logic pen,
                                  inout int run);
      checkValue({tag, "_onehot"}, 8'(g == 4'd0 || $onehot(g)), 8'd1);
      checkValue({tag, "_grant_sel"}, 8'(g[s]), 8'(en));
      checkValue({tag, "_sel_stable"}, 8'(s != ps && pen), 8'd0);
      if (g != 4'd0 && g == pg) run++;
      else run = (g != 4'd0) ? 1 : 0;
      checkValue({tag, "_hold_bound"}, 8'(run <= max_hold), 8'd1);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (q8.size() == 0 || q2.size() == 0) begin
         tests++;
         failed++;
         $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
         return;
      end
      e = q8.pop_front();
      checkValue("h8_grant",   8'(grant8),   8'(e.grant));
      checkValue("h8_sel",     8'(sel8),     8'(e.sel));
      checkValue("h8_bus_en",  8'(bus_en8),  8'(e.bus_en));
      checkValue("h8_preempt", 8'(preempt8), 8'(e.preempt));
      e = q2.pop_front();
      checkValue("h2_grant",   8'(grant2),   8'(e.grant));
      checkValue("h2_sel",     8'(sel2),     8'(e.sel));
      checkValue("h2_bus_en",  8'(bus_en2),  8'(e.bus_en));
      checkValue("h2_preempt", 8'(preempt2), 8'(e.preempt));
      checkInvariants("h8", 8, grant8, sel8, bus_en8, prev_grant8, prev_sel8, prev_en8, run8);
      checkInvariants("h2", 2, grant2, sel2, bus_en2, prev_grant2, prev_sel2, prev_en2, run2);
      prev_grant8 = grant8; prev_sel8 = sel8; prev_en8 = bus_en8;
      prev_grant2 = grant2; prev_sel2 = sel2; prev_en2 = bus_en2;
   endtask

   task automatic applyStimulus(input logic [3:0] r);
      req = r;
      m8 = modelStep(m8, r, 8);
      m2 = modelStep(m2, r, 2);
      q8.push_back(toExp(m8));
      q2.push_back(toExp(m2));
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic clearTracking();
      m8 = modelReset();
      m2 = modelReset();
      q8.delete();
      q2.delete();
      prev_grant8 = 4'd0; prev_sel8 = 2'd0; prev_en8 = 1'b0; run8 = 0;
      prev_grant2 = 4'd0; prev_sel2 = 2'd0; prev_en2 = 1'b0; run2 = 0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkValue({tag, "_grant8"},   8'(grant8),   8'd0);
      checkValue({tag, "_bus_en8"},  8'(bus_en8),  8'd0);
      checkValue({tag, "_preempt8"}, 8'(preempt8), 8'd0);
      checkValue({tag, "_grant2"},   8'(grant2),   8'd0);
      checkValue({tag, "_bus_en2"},  8'(bus_en2),  8'd0);
      checkValue({tag, "_preempt2"}, 8'(preempt2), 8'd0);
   endtask

   task automatic doReset(input logic [3:0] r);
      rst_n = 1'b0;
      req   = r;
      @(posedge clk);
      #1;
      checkResetOutputs("reset");
      checkValue("reset_sel8", 8'(sel8), 8'd0);
      checkValue("reset_sel2", 8'(sel2), 8'd0);
      clearTracking();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'd0;
      clearTracking();
      #2;

      // Full contention: rotation 0,1,2,3,0 with timeout preempts
      doReset(4'b1111);
      for (int i = 0; i < 40; i++) applyStimulus(4'b1111);

      // Single short burst, then idle with sel parked on 2
      doReset(4'b0000);
      for (int i = 0; i < 3; i++) applyStimulus(4'b0100);
      for (int i = 0; i < 3; i++) applyStimulus(4'b0000);
      checkValue("idle_sel8", 8'(sel8), 8'd2);
      checkValue("idle_grant8", 8'(grant8), 8'd0);

      // Lone requester 3: repeated timeout and re-grant
      doReset(4'b0000);
      for (int i = 0; i < 12; i++) applyStimulus(4'b1000);
      checkValue("lone_sel2", 8'(sel2), 8'd3);

      // Owner 1 drops while 0 and 2 wait: 2 wins by rotation, then 0
      doReset(4'b0000);
      applyStimulus(4'b0010);
      applyStimulus(4'b0111);
      applyStimulus(4'b0101);
      applyStimulus(4'b0101);
      applyStimulus(4'b0101);
      applyStimulus(4'b0001);
      applyStimulus(4'b0001);
      applyStimulus(4'b0001);
      applyStimulus(4'b0000);
      applyStimulus(4'b0000);

      // Asynchronous reset in the middle of a grant
      doReset(4'b0000);
      applyStimulus(4'b0010);
      applyStimulus(4'b0010);
      checkValue("pre_async_grant8", 8'(grant8), 8'b0010);
      rst_n = 1'b0;
      #2;
      checkResetOutputs("async");
      clearTracking();
      rst_n = 1'b1;
      applyStimulus(4'b0010);
      checkValue("post_async_grant8", 8'(grant8), 8'b0010);

      // Random traffic, biased toward sustained requests
      doReset(4'b0000);
      for (int i = 0; i < 10000; i++) begin
         logic [3:0] r;
         r = (i % 64 < 32) ? 4'($urandom_range(0, 15)) : (req ^ 4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 0));
         applyStimulus(r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter sharing one bus datapath between four requesters.
- Produces a one-hot grant and a 2-bit select that drives the 4:1 select tree built from 2:1 multiplex cells: sel[0] feeds the first rank, sel[1] the second.
- Bounds each ownership to MAX_HOLD cycles.
- Inserts one idle turnaround cycle between owners so the mux select never changes while a grant is live.

Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles per ownership. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; req[i] is held high while requester i wants the bus.
- grant  output  4  one-hot grant; all zero when no owner.
- sel  output  2  binary index of the current or last owner; drives the mux tree.
- bus_en  output  1  high when any grant is active (equals OR of grant).
- preempt  output  1  one-cycle pulse when an owner loses the bus by timeout.

Behaviour:
- Reset (async, asserted while rst_n=0):
  - grant=0, sel=0, bus_en=0, preempt=0.
  - state=IDLE, hold_cnt=0, last_owner=3, so requester 0 has first priority after reset.
  - Deassertion is sampled synchronously: first arbitration at the first rising edge with rst_n=1.
- All outputs are registered. No combinational path from req to any output.
- States: IDLE, GRANT, TURN.
- IDLE / TURN arbitration:
  - At an edge with req != 0: pick the first i with req[i]=1, scanning last_owner+1, +2, +3, +4 (mod 4).
  - Next state GRANT; grant[i]=1, sel=i, bus_en=1, hold_cnt=0, last_owner=i.
  - Latency is 1 cycle: req sampled at edge k, grant visible after edge k.
  - With req=0: stay or return to IDLE. grant=0, and sel holds its previous value (never glitches).
- GRANT, owner o:
  - At each edge, if req[o]=1 and hold_cnt < MAX_HOLD-1: stay, hold_cnt+1.
  - If req[o]=0: go to TURN. grant=0, bus_en=0, sel held, no preempt.
  - If req[o]=1 and hold_cnt = MAX_HOLD-1: go to TURN. grant=0, preempt=1 for exactly that TURN cycle.
  - Result: one ownership lasts at most MAX_HOLD cycles.
- TURN:
  - Always exactly one cycle with grant=0.
  - Arbitrates as IDLE: a pending request is granted at the end of the TURN cycle. Otherwise go to IDLE.
  - The handover gap between consecutive owners is therefore exactly 1 cycle.
- Fairness:
  - last_owner updates on every grant, so the preempted owner has lowest priority next round.
  - If it is the only requester, it is re-granted after the 1-cycle gap.
- Requests from non-owners during GRANT are ignored until TURN. No queuing and no lost state: req is level, not pulse.
- MAX_HOLD=1: every grant lasts 1 cycle, followed by TURN. preempt pulses whenever the owner's req was still high at the end of its grant cycle.
- Invariants:
  - grant is always 0 or one-hot.
  - grant[sel]=1 whenever bus_en=1.
  - sel changes only on an edge leaving IDLE/TURN into GRANT.
- Reset mid-GRANT: grant, bus_en, and preempt drop immediately (asynchronously). Arbitration restarts with requester 0 highest priority.
- hold_cnt is 8 bits wide. It never reaches MAX_HOLD, so there is no wrap.

Test Plan:
1. Reset with req=4'b1111, release rst_n -> one edge later grant=0001, sel=0, bus_en=1. With MAX_HOLD=8, grant holds 8 cycles; then 1 cycle grant=0, preempt=1; then grant=0010, sel=1. The sequence continues 0100, 1000, 0001.
2. req=4'b0100 for 3 cycles then 0 -> grant=0100, sel=2 for 3 cycles. Then grant=0, preempt=0, state IDLE. sel stays 2 while idle.
3. Only req[3] held high, MAX_HOLD=2 -> repeating pattern: grant=1000 for 2 cycles, 0 for 1 cycle (preempt=1), and so on. sel=3 throughout.
4. Owner 1 granted, req[2] and req[0] raised mid-grant, req[1] drops -> TURN 1 cycle, then grant=0100 (2 beats 0 by rotation), then 0001.
5. Assert rst_n=0 asynchronously between edges during grant=0010 -> grant, bus_en, and preempt read 0 before the next edge. After release with req=4'b0010, grant=0010 one edge later.
6. Random req for 10k cycles -> assert one-hot grant, grant[sel]==bus_en, ownership never exceeds MAX_HOLD cycles, and sel never changes while bus_en=1.
